gba_vram_drawer_responder: RTL and testbench
============================================

Name: gba_vram_drawer_responder

Overview:
- Memory-side responder for the BG-drawer VRAM read interface (addr_Lo/addr_Hi → data/valid).
- Two independent channels, Lo bank (VRAM byte 0x00000-0x0FFFF) and Hi bank (0x10000-0x17FFF), each with its own backing-memory port.
- Each channel holds a one-word registered result tagged with its address; valid is asserted only while the tag matches the drawer's current address.
- Snoops CPU VRAM writes and invalidates stale words, so a drawer never consumes old data.

Parameters:
- LO_AW, 14, Lo-bank word address width (16K x 32-bit words).
- HI_AW, 13, Hi-bank word address width (8K x 32-bit words).

Ports:
- fclk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- VRAM_Drawer_addr_Lo  in  LO_AW  drawer Lo word address
- VRAM_Drawer_addr_Hi  in  HI_AW  drawer Hi word address
- VRAM_Drawer_data_Lo  out  32  Lo result word
- VRAM_Drawer_data_Hi  out  32  Hi result word
- VRAM_Drawer_valid_Lo  out  1  data_Lo corresponds to current addr_Lo
- VRAM_Drawer_valid_Hi  out  1  data_Hi corresponds to current addr_Hi
- lo_mem_req  out  1  Lo read request, held until granted
- lo_mem_addr  out  LO_AW  Lo read word address
- lo_mem_gnt  in  1  Lo request accepted this cycle
- lo_mem_rvalid  in  1  Lo read data return, one per grant, in order
- lo_mem_rdata  in  32  Lo read data
- hi_mem_req / hi_mem_addr / hi_mem_gnt / hi_mem_rvalid / hi_mem_rdata: same signals for the Hi bank, address width HI_AW
- cpu_vram_we  in  1  CPU VRAM write strobe
- cpu_vram_addr  in  17  CPU VRAM byte address; bit 16 selects bank, bits [15:2] / [14:2] give the word

Behaviour:
- Per channel state: tag[AW], tag_valid, data[32], pend_addr[AW], pend_stale, FSM {IDLE, REQ, WAIT}.
- valid_X = tag_valid & (tag == drawer addr_X), combinational compare.
- An address change drops valid in the same cycle. Data output is registered.
- Reset:
  - FSM=IDLE, tag_valid=0, pend_stale=0, data=0, tag=0, mem_req=0.
  - Both valid outputs are 0 from the first cycle after reset.
  - Reset mid-fetch: FSM returns to IDLE. Any late rvalid arriving while in IDLE is ignored.
- IDLE:
  - If !valid_X, capture pend_addr = addr_X, assert mem_req with mem_addr = addr_X, go to REQ.
  - Request is issued in the cycle after the miss is seen.
- REQ:
  - mem_req and mem_addr are held stable until mem_gnt.
  - On gnt: drop req, go to WAIT.
  - A drawer address change during REQ does not change mem_addr.
- WAIT, on mem_rvalid:
  - If !pend_stale: tag = pend_addr, data = rdata, tag_valid = 1.
  - Clear pend_stale, go to IDLE.
  - IDLE re-issues next cycle if the drawer address moved meanwhile.
- Minimum hit latency after an address change: 1 (req) + gnt wait + memory latency + 1 (register). With gnt and rvalid each one cycle after request, valid rises 3 cycles after the address change.
- Same address held: no new request is issued; valid stays high indefinitely.
- CPU snoop, every cycle:
  - bank = cpu_vram_addr[16]; word = [15:2] for Lo, [14:2] for Hi.
  - Write hitting the tag with tag_valid → tag_valid=0.
  - Write hitting pend_addr in REQ or WAIT → pend_stale=1.
  - Write in the same cycle as rvalid for the same word → result discarded, tag_valid=0.
- Hi bank writes with cpu_vram_addr[15]=1 (mirror region) match Hi words on bits [14:2].
- Channels are fully independent; both may fetch concurrently.

Test Plan:
- Reset, then addr_Lo=0x0010 with memory gnt+1 / rvalid+1 returning 0xDEADBEEF → valid_Lo rises exactly 3 cycles later, data_Lo=0xDEADBEEF; lo_mem_req asserted exactly one cycle.
- Valid held on addr_Lo=0x0010, then change to 0x0011 → valid_Lo=0 in the same cycle; refetch completes, valid_Lo=1 with the new word.
- Change addr_Hi from 0x100 to 0x101 while the 0x100 fetch is in WAIT → 0x100 result stored, valid_Hi stays 0, second request for 0x101 issued the next cycle, final valid_Hi=1 with 0x101 data.
- Valid tag Lo 0x0020, CPU write to byte 0x00080 → valid_Lo drops next cycle and a refetch follows. CPU write to byte 0x10080 → valid_Lo unaffected.
- CPU write to the pending Hi word in the same cycle as hi_mem_rvalid → data discarded, valid_Hi stays 0, refetch issued.
- lo_mem_gnt withheld 5 cycles → req and addr stable all 5 cycles, exactly one grant consumed; assert reset during WAIT → all valids 0, req 0, late rvalid ignored.

Source files
------------

// File: rtl/gba_vram_drawer_responder.sv
// gba_vram_drawer_responder: memory-side responder for the BG drawer's VRAM
// read interface. The Lo bank covers VRAM bytes 0x00000-0x0FFFF and the Hi
// bank covers 0x10000-0x17FFF. Each bank has its own backing-memory port and
// keeps one tagged result word. CPU VRAM writes are snooped so that the drawer
// is never handed a word that has since been overwritten.

module gba_vram_drawer_responder #(
   parameter int LO_AW = 14,
   parameter int HI_AW = 13
) (
   input  logic             fclk,
   input  logic             reset,
   input  logic [LO_AW-1:0] VRAM_Drawer_addr_Lo,
   input  logic [HI_AW-1:0] VRAM_Drawer_addr_Hi,
   output logic [31:0]      VRAM_Drawer_data_Lo,
   output logic [31:0]      VRAM_Drawer_data_Hi,
   output logic             VRAM_Drawer_valid_Lo,
   output logic             VRAM_Drawer_valid_Hi,
   output logic             lo_mem_req,
   output logic [LO_AW-1:0] lo_mem_addr,
   input  logic             lo_mem_gnt,
   input  logic             lo_mem_rvalid,
   input  logic [31:0]      lo_mem_rdata,
   output logic             hi_mem_req,
   output logic [HI_AW-1:0] hi_mem_addr,
   input  logic             hi_mem_gnt,
   input  logic             hi_mem_rvalid,
   input  logic [31:0]      hi_mem_rdata,
   input  logic             cpu_vram_we,
   input  logic [16:0]      cpu_vram_addr
);

   logic             lo_snoop_we;
   logic             hi_snoop_we;
   logic [LO_AW-1:0] lo_snoop_word;
   logic [HI_AW-1:0] hi_snoop_word;
   logic             unused_byte_lane;

   // Bit 16 picks the bank. The Hi bank ignores bit 15, so writes into the
   // 0x18000-0x1FFFF mirror land on the same Hi words as 0x10000-0x17FFF.
   assign lo_snoop_we      = cpu_vram_we & ~cpu_vram_addr[16];
   assign hi_snoop_we      = cpu_vram_we &  cpu_vram_addr[16];
   assign lo_snoop_word    = cpu_vram_addr[LO_AW+1:2];
   assign hi_snoop_word    = cpu_vram_addr[HI_AW+1:2];
   assign unused_byte_lane = ^cpu_vram_addr[1:0];

   gba_vram_drawer_channel #(
      .AW (LO_AW)
   ) lo_channel (
      .clk          (fclk),
      .reset        (reset),
      .drawer_addr  (VRAM_Drawer_addr_Lo),
      .drawer_data  (VRAM_Drawer_data_Lo),
      .drawer_valid (VRAM_Drawer_valid_Lo),
      .mem_req      (lo_mem_req),
      .mem_addr     (lo_mem_addr),
      .mem_gnt      (lo_mem_gnt),
      .mem_rvalid   (lo_mem_rvalid),
      .mem_rdata    (lo_mem_rdata),
      .snoop_we     (lo_snoop_we),
      .snoop_word   (lo_snoop_word)
   );

   gba_vram_drawer_channel #(
      .AW (HI_AW)
   ) hi_channel (
      .clk          (fclk),
      .reset        (reset),
      .drawer_addr  (VRAM_Drawer_addr_Hi),
      .drawer_data  (VRAM_Drawer_data_Hi),
      .drawer_valid (VRAM_Drawer_valid_Hi),
      .mem_req      (hi_mem_req),
      .mem_addr     (hi_mem_addr),
      .mem_gnt      (hi_mem_gnt),
      .mem_rvalid   (hi_mem_rvalid),
      .mem_rdata    (hi_mem_rdata),
      .snoop_we     (hi_snoop_we),
      .snoop_word   (hi_snoop_word)
   );

endmodule

// gba_vram_drawer_channel: one bank's worth of responder. It holds a single
// registered word tagged with its word address and fetches a new word whenever
// the drawer asks for an address that the tag does not cover.

module gba_vram_drawer_channel #(
   parameter int AW = 14
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [AW-1:0] drawer_addr,
   output logic [31:0]   drawer_data,
   output logic          drawer_valid,
   output logic          mem_req,
   output logic [AW-1:0] mem_addr,
   input  logic          mem_gnt,
   input  logic          mem_rvalid,
   input  logic [31:0]   mem_rdata,
   input  logic          snoop_we,
   input  logic [AW-1:0] snoop_word
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT
   } state_t;

   state_t        state;
   logic [AW-1:0] tag;
   logic          tag_valid;
   logic [AW-1:0] pend_addr;
   logic          pend_stale;
   logic          hit_tag;
   logic          hit_pend;

   // The compare is combinational so that a drawer address change drops
   // valid in the very cycle it happens.
   assign drawer_valid = tag_valid && (tag == drawer_addr);
   assign hit_tag      = snoop_we && tag_valid && (snoop_word == tag);
   assign hit_pend     = snoop_we && (snoop_word == pend_addr);

   // Fetch sequencer, result register and CPU-write snooping for this bank
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_IDLE;
         tag         <= '0;
         tag_valid   <= 1'b0;
         drawer_data <= '0;
         pend_addr   <= '0;
         pend_stale  <= 1'b0;
         mem_req     <= 1'b0;
         mem_addr    <= '0;
      end else begin
         if (hit_tag) begin
            tag_valid <= 1'b0;
         end

         case (state)
            ST_IDLE: begin
               // A return that straggles in after reset lands here and is
               // deliberately not looked at.
               if (!drawer_valid) begin
                  pend_addr  <= drawer_addr;
                  pend_stale <= 1'b0;
                  mem_req    <= 1'b1;
                  mem_addr   <= drawer_addr;
                  state      <= ST_REQ;
               end
            end

            ST_REQ: begin
               // The address stays frozen here even if the drawer moves on;
               // the next IDLE visit catches up with the new address.
               if (hit_pend) begin
                  pend_stale <= 1'b1;
               end
               if (mem_gnt) begin
                  mem_req <= 1'b0;
                  state   <= ST_WAIT;
               end
            end

            ST_WAIT: begin
               if (mem_rvalid) begin
                  if (!pend_stale && !hit_pend) begin
                     tag         <= pend_addr;
                     drawer_data <= mem_rdata;
                     tag_valid   <= 1'b1;
                  end else if (hit_pend) begin
                     tag_valid <= 1'b0;
                  end
                  pend_stale <= 1'b0;
                  state      <= ST_IDLE;
               end else if (hit_pend) begin
                  pend_stale <= 1'b1;
               end
            end

            default: begin
               state   <= ST_IDLE;
               mem_req <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gba_vram_drawer_responder.sv
// tb_gba_vram_drawer_responder: self-checking bench for the drawer VRAM
// responder. A behavioural memory per bank grants and returns words; expected
// drawer words are queued when an address is driven and popped when valid rises.

module tb_gba_vram_drawer_responder;

   localparam int LO_AW = 14;
   localparam int HI_AW = 13;

   logic             fclk = 1'b0;
   logic             reset;
   logic [LO_AW-1:0] VRAM_Drawer_addr_Lo;
   logic [HI_AW-1:0] VRAM_Drawer_addr_Hi;
   logic [31:0]      VRAM_Drawer_data_Lo;
   logic [31:0]      VRAM_Drawer_data_Hi;
   logic             VRAM_Drawer_valid_Lo;
   logic             VRAM_Drawer_valid_Hi;
   logic             lo_mem_req;
   logic [LO_AW-1:0] lo_mem_addr;
   logic             lo_mem_gnt;
   logic             lo_mem_rvalid;
   logic [31:0]      lo_mem_rdata;
   logic             hi_mem_req;
   logic [HI_AW-1:0] hi_mem_addr;
   logic             hi_mem_gnt;
   logic             hi_mem_rvalid;
   logic [31:0]      hi_mem_rdata;
   logic             cpu_vram_we;
   logic [16:0]      cpu_vram_addr;

   logic        lo_gnt_en = 1'b1;
   logic        hi_gnt_en = 1'b1;
   int          lo_lat = 1;
   int          hi_lat = 1;
   int          cyc = 0;
   int          lo_grants = 0;
   int          hi_grants = 0;
   int          checks = 0;
   int          failures = 0;

   logic [31:0] lo_mem [0:(1<<LO_AW)-1];
   logic [31:0] hi_mem [0:(1<<HI_AW)-1];
   logic [31:0] lo_ret_data [$];
   int          lo_ret_due [$];
   logic [31:0] hi_ret_data [$];
   int          hi_ret_due [$];
   logic [31:0] exp_lo [$];
   logic [31:0] exp_hi [$];

   gba_vram_drawer_responder #(
      .LO_AW (LO_AW),
      .HI_AW (HI_AW)
   ) dut (
      .fclk                 (fclk),
      .reset                (reset),
      .VRAM_Drawer_addr_Lo  (VRAM_Drawer_addr_Lo),
      .VRAM_Drawer_addr_Hi  (VRAM_Drawer_addr_Hi),
      .VRAM_Drawer_data_Lo  (VRAM_Drawer_data_Lo),
      .VRAM_Drawer_data_Hi  (VRAM_Drawer_data_Hi),
      .VRAM_Drawer_valid_Lo (VRAM_Drawer_valid_Lo),
      .VRAM_Drawer_valid_Hi (VRAM_Drawer_valid_Hi),
      .lo_mem_req           (lo_mem_req),
      .lo_mem_addr          (lo_mem_addr),
      .lo_mem_gnt           (lo_mem_gnt),
      .lo_mem_rvalid        (lo_mem_rvalid),
      .lo_mem_rdata         (lo_mem_rdata),
      .hi_mem_req           (hi_mem_req),
      .hi_mem_addr          (hi_mem_addr),
      .hi_mem_gnt           (hi_mem_gnt),
      .hi_mem_rvalid        (hi_mem_rvalid),
      .hi_mem_rdata         (hi_mem_rdata),
      .cpu_vram_we          (cpu_vram_we),
      .cpu_vram_addr        (cpu_vram_addr)
   );

   // Grant is given in the same cycle the request is seen whenever enabled
   assign lo_mem_gnt = lo_mem_req & lo_gnt_en;
   assign hi_mem_gnt = hi_mem_req & hi_gnt_en;

   // Free-running clock
   always #5 fclk = ~fclk;

   // Behavioural memory: records grants at mid-cycle, returns data lat cycles later
   initial begin
      lo_mem_rvalid = 1'b0;
      lo_mem_rdata  = '0;
      hi_mem_rvalid = 1'b0;
      hi_mem_rdata  = '0;
      forever begin
         @(negedge fclk);
         if (lo_mem_req === 1'b1 && lo_mem_gnt === 1'b1) begin
            lo_ret_data.push_back(lo_mem[lo_mem_addr]);
            lo_ret_due.push_back(cyc + lo_lat);
            lo_grants++;
         end
         if (hi_mem_req === 1'b1 && hi_mem_gnt === 1'b1) begin
            hi_ret_data.push_back(hi_mem[hi_mem_addr]);
            hi_ret_due.push_back(cyc + hi_lat);
            hi_grants++;
         end
         @(posedge fclk);
         #1;
         cyc++;
         lo_mem_rvalid = 1'b0;
         hi_mem_rvalid = 1'b0;
         if (lo_ret_due.size() > 0 && lo_ret_due[0] <= cyc) begin
            lo_mem_rvalid = 1'b1;
            lo_mem_rdata  = lo_ret_data.pop_front();
            void'(lo_ret_due.pop_front());
         end
         if (hi_ret_due.size() > 0 && hi_ret_due[0] <= cyc) begin
            hi_mem_rvalid = 1'b1;
            hi_mem_rdata  = hi_ret_data.pop_front();
            void'(hi_ret_due.pop_front());
         end
      end
   end

   // Last-resort guard against a hung run
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic next_cycle();
      @(posedge fclk);
      #1;
   endtask

   // Waits for valid on one bank, then pops the scoreboard and checks data and latency
   task automatic await_word(input bit hi, input string name, input int want_lat);
      int          lat;
      bit          seen;
      logic [31:0] want;
      logic [31:0] got;
      lat  = 0;
      seen = 1'b0;
      for (int i = 0; i < 32 && !seen; i++) begin
         @(negedge fclk);
         if ((hi ? VRAM_Drawer_valid_Hi : VRAM_Drawer_valid_Lo) === 1'b1) begin
            seen = 1'b1;
         end else begin
            next_cycle();
            lat++;
         end
      end
      checks++;
      if (!seen) begin
         failures++;
         $display("[TB] FAIL %s: valid never rose within 32 cycles (got 0, want 1)", name);
      end else if ((hi ? exp_hi.size() : exp_lo.size()) == 0) begin
         failures++;
         $display("[TB] FAIL %s: valid rose with no expected word queued", name);
      end else begin
         want = hi ? exp_hi.pop_front() : exp_lo.pop_front();
         got  = hi ? VRAM_Drawer_data_Hi : VRAM_Drawer_data_Lo;
         if (got !== want) begin
            failures++;
            $display("[TB] FAIL %s data: got %h want %h", name, got, want);
         end
         if (want_lat >= 0) begin
            checks++;
            if (lat != want_lat) begin
               failures++;
               $display("[TB] FAIL %s latency: got %0d want %0d", name, lat, want_lat);
            end
         end
      end
   endtask

   task automatic test_reset();
      reset               = 1'b1;
      VRAM_Drawer_addr_Lo = 14'h0010;
      VRAM_Drawer_addr_Hi = 13'h0100;
      cpu_vram_we         = 1'b0;
      cpu_vram_addr       = '0;
      next_cycle();
      next_cycle();
      @(negedge fclk);
      checks++; if (VRAM_Drawer_valid_Lo !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid_lo: got %b want 0", VRAM_Drawer_valid_Lo); end
      checks++; if (VRAM_Drawer_valid_Hi !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid_hi: got %b want 0", VRAM_Drawer_valid_Hi); end
      checks++; if (lo_mem_req !== 1'b0) begin failures++; $display("[TB] FAIL reset_lo_req: got %b want 0", lo_mem_req); end
      checks++; if (hi_mem_req !== 1'b0) begin failures++; $display("[TB] FAIL reset_hi_req: got %b want 0", hi_mem_req); end
      checks++; if (VRAM_Drawer_data_Lo !== 32'h0) begin failures++; $display("[TB] FAIL reset_data_lo: got %h want 0", VRAM_Drawer_data_Lo); end
      checks++; if (VRAM_Drawer_data_Hi !== 32'h0) begin failures++; $display("[TB] FAIL reset_data_hi: got %h want 0", VRAM_Drawer_data_Hi); end
      next_cycle();
   endtask

   task automatic test_first_fetch();
      reset = 1'b0;
      exp_lo.push_back(lo_mem[14'h0010]);
      exp_hi.push_back(hi_mem[13'h0100]);
      @(negedge fclk);
      checks++; if (lo_mem_req !== 1'b0) begin failures++; $display("[TB] FAIL first_req_c0: got %b want 0", lo_mem_req); end
      next_cycle();
      @(negedge fclk);
      checks++; if (lo_mem_req !== 1'b1) begin failures++; $display("[TB] FAIL first_req_c1: got %b want 1", lo_mem_req); end
      checks++; if (lo_mem_addr !== 14'h0010) begin failures++; $display("[TB] FAIL first_addr_c1: got %h want 0010", lo_mem_addr); end
      checks++; if (VRAM_Drawer_valid_Lo !== 1'b0) begin failures++; $display("[TB] FAIL first_valid_c1: got %b want 0", VRAM_Drawer_valid_Lo); end
      next_cycle();
      @(negedge fclk);
      checks++; if (lo_mem_req !== 1'b0) begin failures++; $display("[TB] FAIL first_req_c2: got %b want 0", lo_mem_req); end
      checks++; if (VRAM_Drawer_valid_Lo !== 1'b0) begin failures++; $display("[TB] FAIL first_valid_c2: got %b want 0", VRAM_Drawer_valid_Lo); end
      next_cycle();
      await_word(1'b0, "first_fetch_lo", 0);
      next_cycle();
      await_word(1'b1, "first_fetch_hi", -1);
      next_cycle();
   endtask

   task automatic test_hold_and_change();
      for (int i = 0; i < 4; i++) begin
         @(negedge fclk);
         checks++; if (VRAM_Drawer_valid_Lo !== 1'b1) begin failures++; $display("[TB] FAIL hold_valid[%0d]: got %b want 1", i, VRAM_Drawer_valid_Lo); end
         checks++; if (lo_mem_req !== 1'b0) begin failures++; $display("[TB] FAIL hold_no_req[%0d]: got %b want 0", i, lo_mem_req); end
         next_cycle();
      end
      VRAM_Drawer_addr_Lo = 14'h0011;
      exp_lo.push_back(lo_mem[14'h0011]);
      @(negedge fclk);
      checks++; if (VRAM_Drawer_valid_Lo !== 1'b0) begin failures++; $display("[TB] FAIL change_drop: got %b want 0", VRAM_Drawer_valid_Lo); end
      next_cycle();
      await_word(1'b0, "refetch_0011", 2);
      next_cycle();
   endtask

   task automatic test_change_during_wait();
      hi_lat = 2;
      VRAM_Drawer_addr_Hi = 13'h0050;
      exp_hi.push_back(hi_mem[13'h0050]);
      await_word(1'b1, "hi_0050", 4);
      next_cycle();
      VRAM_Drawer_addr_Hi = 13'h0100;
      @(negedge fclk);
      checks++; if (VRAM_Drawer_valid_Hi !== 1'b0) begin failures++; $display("[TB] FAIL cdw_valid_c0: got %b want 0", VRAM_Drawer_valid_Hi); end
      next_cycle();
      @(negedge fclk);
      checks++; if (hi_mem_req !== 1'b1 || hi_mem_addr !== 13'h0100) begin failures++; $display("[TB] FAIL cdw_req_0100: got req=%b addr=%h want req=1 addr=0100", hi_mem_req, hi_mem_addr); end
      next_cycle();
      VRAM_Drawer_addr_Hi = 13'h0101;
      exp_hi.push_back(hi_mem[13'h0101]);
      @(negedge fclk);
      checks++; if (VRAM_Drawer_valid_Hi !== 1'b0) begin failures++; $display("[TB] FAIL cdw_valid_c2: got %b want 0", VRAM_Drawer_valid_Hi); end
      next_cycle();
      @(negedge fclk);
      checks++; if (VRAM_Drawer_valid_Hi !== 1'b0) begin failures++; $display("[TB] FAIL cdw_valid_c3: got %b want 0", VRAM_Drawer_valid_Hi); end
      next_cycle();
      @(negedge fclk);
      checks++; if (VRAM_Drawer_valid_Hi !== 1'b0) begin failures++; $display("[TB] FAIL cdw_valid_c4: got %b want 0", VRAM_Drawer_valid_Hi); end
      checks++; if (hi_mem_req !== 1'b0) begin failures++; $display("[TB] FAIL cdw_req_c4: got %b want 0", hi_mem_req); end
      next_cycle();
      @(negedge fclk);
      checks++; if (hi_mem_req !== 1'b1 || hi_mem_addr !== 13'h0101) begin failures++; $display("[TB] FAIL cdw_req_0101: got req=%b addr=%h want req=1 addr=0101", hi_mem_req, hi_mem_addr); end
      next_cycle();
      await_word(1'b1, "hi_0101", 2);
      next_cycle();
      hi_lat = 1;
   endtask

   task automatic test_snoop();
      VRAM_Drawer_addr_Lo = 14'h0020;
      exp_lo.push_back(lo_mem[14'h0020]);
      await_word(1'b0, "lo_0020", 3);
      next_cycle();
      cpu_vram_we   = 1'b1;
      cpu_vram_addr = 17'h00080;
      lo_mem[14'h0020] = 32'h5EED_0020;
      exp_lo.push_back(32'h5EED_0020);
      @(negedge fclk);
      checks++; if (VRAM_Drawer_valid_Lo !== 1'b1) begin failures++; $display("[TB] FAIL snoop_valid_c0: got %b want 1", VRAM_Drawer_valid_Lo); end
      next_cycle();
      cpu_vram_we = 1'b0;
      @(negedge fclk);
      checks++; if (VRAM_Drawer_valid_Lo !== 1'b0) begin failures++; $display("[TB] FAIL snoop_valid_c1: got %b want 0", VRAM_Drawer_valid_Lo); end
      next_cycle();
      @(negedge fclk);
      checks++; if (lo_mem_req !== 1'b1 || lo_mem_addr !== 14'h0020) begin failures++; $display("[TB] FAIL snoop_refetch_req: got req=%b addr=%h want req=1 addr=0020", lo_mem_req, lo_mem_addr); end
      next_cycle();
      await_word(1'b0, "snoop_refetch", 1);
      next_cycle();
      cpu_vram_we   = 1'b1;
      cpu_vram_addr = 17'h10080;
      hi_mem[13'h0020] = 32'h0BAD_0020;
      next_cycle();
      cpu_vram_we = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge fclk);
         checks++; if (VRAM_Drawer_valid_Lo !== 1'b1) begin failures++; $display("[TB] FAIL other_bank_valid[%0d]: got %b want 1", i, VRAM_Drawer_valid_Lo); end
         checks++; if (lo_mem_req !== 1'b0) begin failures++; $display("[TB] FAIL other_bank_req[%0d]: got %b want 0", i, lo_mem_req); end
         next_cycle();
      end
      cpu_vram_we   = 1'b1;
      cpu_vram_addr = 17'h18404;
      hi_mem[13'h0101] = 32'h3141_5926;
      exp_hi.push_back(32'h3141_5926);
      @(negedge fclk);
      checks++; if (VRAM_Drawer_valid_Hi !== 1'b1) begin failures++; $display("[TB] FAIL mirror_valid_c0: got %b want 1", VRAM_Drawer_valid_Hi); end
      next_cycle();
      cpu_vram_we = 1'b0;
      @(negedge fclk);
      checks++; if (VRAM_Drawer_valid_Hi !== 1'b0) begin failures++; $display("[TB] FAIL mirror_valid_c1: got %b want 0", VRAM_Drawer_valid_Hi); end
      next_cycle();
      await_word(1'b1, "mirror_refetch", 2);
      next_cycle();
   endtask

   task automatic test_snoop_same_cycle();
      VRAM_Drawer_addr_Hi = 13'h0102;
      @(negedge fclk);
      checks++; if (VRAM_Drawer_valid_Hi !== 1'b0) begin failures++; $display("[TB] FAIL same_valid_c0: got %b want 0", VRAM_Drawer_valid_Hi); end
      next_cycle();
      @(negedge fclk);
      checks++; if (hi_mem_req !== 1'b1 || hi_mem_addr !== 13'h0102) begin failures++; $display("[TB] FAIL same_req_c1: got req=%b addr=%h want req=1 addr=0102", hi_mem_req, hi_mem_addr); end
      next_cycle();
      cpu_vram_we   = 1'b1;
      cpu_vram_addr = 17'h10408;
      hi_mem[13'h0102] = 32'hFACE_0102;
      exp_hi.push_back(32'hFACE_0102);
      next_cycle();
      cpu_vram_we = 1'b0;
      @(negedge fclk);
      checks++; if (VRAM_Drawer_valid_Hi !== 1'b0) begin failures++; $display("[TB] FAIL same_discard_valid: got %b want 0", VRAM_Drawer_valid_Hi); end
      checks++; if (hi_mem_req !== 1'b0) begin failures++; $display("[TB] FAIL same_req_c3: got %b want 0", hi_mem_req); end
      next_cycle();
      @(negedge fclk);
      checks++; if (hi_mem_req !== 1'b1 || hi_mem_addr !== 13'h0102) begin failures++; $display("[TB] FAIL same_refetch_req: got req=%b addr=%h want req=1 addr=0102", hi_mem_req, hi_mem_addr); end
      next_cycle();
      await_word(1'b1, "same_refetch", 1);
      next_cycle();
   endtask

   task automatic test_gnt_withheld_reset();
      int g0;
      g0        = lo_grants;
      lo_gnt_en = 1'b0;
      lo_lat    = 3;
      VRAM_Drawer_addr_Lo = 14'h0030;
      exp_lo.push_back(lo_mem[14'h0030]);
      next_cycle();
      for (int i = 0; i < 5; i++) begin
         @(negedge fclk);
         checks++; if (lo_mem_req !== 1'b1) begin failures++; $display("[TB] FAIL stall_req[%0d]: got %b want 1", i, lo_mem_req); end
         checks++; if (lo_mem_addr !== 14'h0030) begin failures++; $display("[TB] FAIL stall_addr[%0d]: got %h want 0030", i, lo_mem_addr); end
         next_cycle();
      end
      lo_gnt_en = 1'b1;
      next_cycle();
      reset = 1'b1;
      @(negedge fclk);
      checks++; if (lo_mem_req !== 1'b0) begin failures++; $display("[TB] FAIL stall_req_drop: got %b want 0", lo_mem_req); end
      checks++; if (lo_grants - g0 != 1) begin failures++; $display("[TB] FAIL stall_grants: got %0d want 1", lo_grants - g0); end
      next_cycle();
      @(negedge fclk);
      checks++; if (VRAM_Drawer_valid_Lo !== 1'b0 || VRAM_Drawer_valid_Hi !== 1'b0) begin failures++; $display("[TB] FAIL midreset_valids: got lo=%b hi=%b want 0 0", VRAM_Drawer_valid_Lo, VRAM_Drawer_valid_Hi); end
      checks++; if (lo_mem_req !== 1'b0 || hi_mem_req !== 1'b0) begin failures++; $display("[TB] FAIL midreset_reqs: got lo=%b hi=%b want 0 0", lo_mem_req, hi_mem_req); end
      next_cycle();
      reset = 1'b0;
      @(negedge fclk);
      checks++; if (VRAM_Drawer_valid_Lo !== 1'b0) begin failures++; $display("[TB] FAIL late_valid_c9: got %b want 0", VRAM_Drawer_valid_Lo); end
      next_cycle();
      lo_lat = 1;
      @(negedge fclk);
      checks++; if (VRAM_Drawer_valid_Lo !== 1'b0) begin failures++; $display("[TB] FAIL late_rvalid_ignored: got %b want 0", VRAM_Drawer_valid_Lo); end
      checks++; if (lo_mem_req !== 1'b1 || lo_mem_addr !== 14'h0030) begin failures++; $display("[TB] FAIL post_reset_req: got req=%b addr=%h want req=1 addr=0030", lo_mem_req, lo_mem_addr); end
      next_cycle();
      await_word(1'b0, "post_reset_fetch", 1);
      next_cycle();
   endtask

   task automatic test_scoreboard_drained();
      checks++; if (exp_lo.size() != 0) begin failures++; $display("[TB] FAIL lo_scoreboard_left: got %0d want 0", exp_lo.size()); end
      checks++; if (exp_hi.size() != 0) begin failures++; $display("[TB] FAIL hi_scoreboard_left: got %0d want 0", exp_hi.size()); end
   endtask

   // Test sequence
   initial begin
      for (int i = 0; i < (1 << LO_AW); i++) lo_mem[i] = 32'hC0DE_0000 ^ 32'(i);
      for (int i = 0; i < (1 << HI_AW); i++) hi_mem[i] = 32'hB0B0_0000 ^ 32'(i);
      lo_mem[14'h0010] = 32'hDEAD_BEEF;
      test_reset();
      test_first_fetch();
      test_hold_and_change();
      test_change_during_wait();
      test_snoop();
      test_snoop_same_cycle();
      test_gnt_withheld_reset();
      test_scoreboard_drained();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
